uart_rx_fsm: RTL and testbench

Receive-side controller for the UART RX path. Runs the edge and bit counters, sequences each frame through start, data, optional parity and stop bits, and enables the deserializer during data bits. Checks parity and stop bits against the majority-voted `sampled_bit` and issues a one-cycle `data_valid` strobe when a frame is error-free. Sits between the data sampler and the deserializer in the UART RX top.

---
 rtl/uart_rx_pkg.sv | 18 +
 rtl/uart_rx_fsm_if.sv | 28 ++
 rtl/uart_rx_edge_bit_counter.sv | 45 ++++
 rtl/uart_rx_fsm.sv | 136 +++++++++++++
 tb/tb_uart_rx_fsm.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - state encoding, parity constants and parity check helper for the UART RX controller
package uart_rx_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // High when received parity disagrees with the data for the selected parity type.
  function automatic logic parity_error(input logic data_xor, input logic par_bit, input logic par_typ);
    return (data_xor ^ par_bit) ^ par_typ;
  endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// rtl/uart_rx_fsm_if.sv - sampler/deserializer side bundle of the UART RX controller
interface uart_rx_fsm_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int EDGE_CNT_WIDTH = 3,
  parameter int BIT_CNT_WIDTH  = 4
);

  logic                      sampled_bit;
  logic [DATA_WIDTH-1:0]     P_DATA;
  logic [EDGE_CNT_WIDTH-1:0] edge_cnt;
  logic [BIT_CNT_WIDTH-1:0]  bit_cnt;
  logic                      dat_samp_en;
  logic                      deser_en;
  logic                      data_valid;
  logic                      par_err;
  logic                      stp_err;

  modport master (
    input  sampled_bit, P_DATA,
    output edge_cnt, bit_cnt, dat_samp_en, deser_en, data_valid, par_err, stp_err
  );

  modport slave (
    output sampled_bit, P_DATA,
    input  edge_cnt, bit_cnt, dat_samp_en, deser_en, data_valid, par_err, stp_err
  );

endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// rtl/uart_rx_edge_bit_counter.sv - oversampling edge counter and data-bit counter
module uart_rx_edge_bit_counter #(
  parameter int EDGE_CNT_WIDTH = 3,
  parameter int BIT_CNT_WIDTH  = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      cnt_en_i,
  input  logic                      bit_en_i,
  output logic [EDGE_CNT_WIDTH-1:0] edge_cnt_o,
  output logic [BIT_CNT_WIDTH-1:0]  bit_cnt_o,
  output logic                      bit_end_o
);

  logic [EDGE_CNT_WIDTH-1:0] edge_q, edge_d;
  logic [BIT_CNT_WIDTH-1:0]  bit_q, bit_d;

  assign bit_end_o  = &edge_q;
  assign edge_cnt_o = edge_q;
  assign bit_cnt_o  = bit_q;

  // Dropping cnt_en (IDLE) clears both; START always follows IDLE so the bit count is already zero there.
  always_comb begin
    edge_d = '0;
    bit_d  = '0;
    if (cnt_en_i) begin
      edge_d = edge_q + 1'b1;
      bit_d  = bit_q;
      if (bit_en_i && bit_end_o) begin
        bit_d = bit_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - UART RX frame sequencer; parity support built only with UART_RX_PARITY_EN defined
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int EDGE_CNT_WIDTH = 3,
  parameter int BIT_CNT_WIDTH  = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           RX_IN,
  input  logic           PAR_EN,
  input  logic           PAR_TYP,
  uart_rx_fsm_if.master  bus
);

  localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

  logic [2:0] state_q, state_d;
  logic       stp_err_q, stp_err_d;
  logic       data_valid_q, data_valid_d;
  logic       bit_end;
  logic       start_ok;
  logic       par_sel;
  logic       par_err_cur;

  uart_rx_edge_bit_counter #(
    .EDGE_CNT_WIDTH (EDGE_CNT_WIDTH),
    .BIT_CNT_WIDTH  (BIT_CNT_WIDTH)
  ) u_counter (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .cnt_en_i   (state_q != S_IDLE),
    .bit_en_i   (state_q == S_DATA),
    .edge_cnt_o (bus.edge_cnt),
    .bit_cnt_o  (bus.bit_cnt),
    .bit_end_o  (bit_end)
  );

  assign start_ok = (state_q == S_START) && bit_end && !bus.sampled_bit;

`ifdef UART_RX_PARITY_EN
  logic par_en_q, par_typ_q;
  logic par_err_q, par_err_d;

  always_comb begin
    par_err_d = par_err_q;
    if (start_ok) begin
      par_err_d = 1'b0;
    end else if (state_q == S_PARITY && bit_end) begin
      par_err_d = parity_error(^bus.P_DATA, bus.sampled_bit, par_typ_q);
    end
  end

  // Frame parity settings are captured at start detection so mid-frame changes have no effect.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
      par_err_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && !RX_IN) begin
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
      end
      par_err_q <= par_err_d;
    end
  end

  assign par_sel     = par_en_q;
  assign par_err_cur = par_err_q;
`else
  logic unused_par;
  assign unused_par  = PAR_EN ^ PAR_TYP ^ (^bus.P_DATA);
  assign par_sel     = 1'b0;
  assign par_err_cur = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    stp_err_d    = stp_err_q;
    data_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!RX_IN) state_d = S_START;
      end
      S_START: begin
        if (bit_end) begin
          if (bus.sampled_bit) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            stp_err_d = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (bit_end && bus.bit_cnt == LAST_BIT) begin
          state_d = par_sel ? S_PARITY : S_STOP;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          stp_err_d    = ~bus.sampled_bit;
          data_valid_d = bus.sampled_bit & ~par_err_cur;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      stp_err_q    <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      stp_err_q    <= stp_err_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign bus.dat_samp_en = (state_q != S_IDLE);
  assign bus.deser_en    = (state_q == S_DATA);
  assign bus.data_valid  = data_valid_q;
  assign bus.stp_err     = stp_err_q;
  assign bus.par_err     = par_err_cur;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb/tb_uart_rx_fsm.sv - directed scoreboard bench for uart_rx_fsm
module tb_uart_rx_fsm;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic RX_IN = 1'b1;
  logic PAR_EN = 1'b0;
  logic PAR_TYP = 1'b0;
  logic sampled_m = 1'b1;
  logic [7:0] p_data_m = 8'h00;

  int tests = 0;
  int fails = 0;
  int deser_cycles = 0;
  int valid_cnt = 0;
  logic prev_valid = 1'b0;
  logic exp_par = 1'b0;
  logic exp_stp = 1'b0;
  logic [7:0] sb[$];

  uart_rx_fsm_if bus ();

  assign bus.sampled_bit = sampled_m;
  assign bus.P_DATA      = p_data_m;

  uart_rx_fsm dut (
    .CLK     (CLK),
    .RST     (RST),
    .RX_IN   (RX_IN),
    .PAR_EN  (PAR_EN),
    .PAR_TYP (PAR_TYP),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  // LSB-first deserializer model shifting at each data bit end.
  always @(posedge CLK) begin
    if (bus.deser_en && (&bus.edge_cnt)) p_data_m <= {sampled_m, p_data_m[7:1]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (bus.deser_en) deser_cycles++;
    if (bus.data_valid) begin
      valid_cnt++;
      check("valid_one_cycle", {31'd0, prev_valid}, 0);
      if (sb.size() != 0) begin
        logic [7:0] exp_d;
        exp_d = sb.pop_front();
        check("p_data_at_valid", {24'd0, bus.P_DATA}, {24'd0, exp_d});
        check("errs_at_valid", {30'd0, bus.par_err, bus.stp_err}, 0);
      end else begin
        check("unexpected_valid", {31'd0, bus.data_valid}, 0);
      end
    end
    prev_valid = bus.data_valid;
  end

  task automatic send_frame(input logic [7:0] data, input logic par_en, input logic par_typ,
                            input logic par_bit, input logic stop);
    logic [11:0] bits;
    int nbits;
    logic in_par;
    logic exp_valid;
    in_par = par_en & PAR_BUILT;
    bits = '0;
    bits[8:1] = data;
    if (in_par) begin
      bits[9] = par_bit;
      bits[10] = stop;
      nbits = 11;
      exp_par = parity_calc(data, par_bit, par_typ);
    end else begin
      bits[9] = stop;
      nbits = 10;
      exp_par = 1'b0;
    end
    exp_stp = ~stop;
    exp_valid = stop & ~exp_par;
    if (exp_valid) sb.push_back(data);
    deser_cycles = 0;
    valid_cnt = 0;
    PAR_EN = par_en;
    PAR_TYP = par_typ;
    RX_IN = 1'b0;
    sampled_m = 1'b0;
    @(negedge CLK);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < 8; c++) begin
        RX_IN = bits[b];
        sampled_m = bits[b];
        if (b == 3 && c == 0) begin
          PAR_EN = ~par_en;
          PAR_TYP = ~par_typ;
        end
        if (b == nbits - 1 && c == 7) check("busy_before_end", {31'd0, bus.dat_samp_en}, 1);
        @(negedge CLK);
      end
    end
    RX_IN = 1'b1;
    sampled_m = 1'b1;
    #1;
    check("idle_after_frame", {31'd0, bus.dat_samp_en}, 0);
    check("deser_cycles", deser_cycles, 64);
    check("valid_count", valid_cnt, {31'd0, exp_valid});
    check("par_err", {31'd0, bus.par_err}, {31'd0, exp_par});
    check("stp_err", {31'd0, bus.stp_err}, {31'd0, exp_stp});
    check("sb_drained", sb.size(), 0);
  endtask

  function automatic logic parity_calc(input logic [7:0] d, input logic pb, input logic typ);
    logic ones_odd;
    ones_odd = 1'b0;
    for (int i = 0; i < 8; i++) ones_odd = ones_odd ^ d[i];
    // Even parity expects total ones even; odd parity expects total ones odd.
    return (typ == 1'b0) ? (ones_odd ^ pb) : ~(ones_odd ^ pb);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_edge"}, {29'd0, bus.edge_cnt}, 0);
    check({tag, "_bit"}, {28'd0, bus.bit_cnt}, 0);
    check({tag, "_outs"}, {27'd0, bus.dat_samp_en, bus.deser_en, bus.data_valid, bus.par_err, bus.stp_err}, 0);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("idle_no_rx", {31'd0, bus.dat_samp_en}, 0);

    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef UART_RX_PARITY_EN
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b1);
`else
    send_frame(8'hC3, 1'b1, 1'b1, 1'b1, 1'b1);
`endif
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);

    // Start glitch: line low for two clocks, sampler reports 1 at start bit end.
    deser_cycles = 0;
    RX_IN = 1'b0;
    sampled_m = 1'b0;
    repeat (2) @(negedge CLK);
    RX_IN = 1'b1;
    sampled_m = 1'b1;
    repeat (6) @(negedge CLK);
    check("glitch_busy", {31'd0, bus.dat_samp_en}, 1);
    @(negedge CLK);
    #1;
    check("glitch_idle", {31'd0, bus.dat_samp_en}, 0);
    check("glitch_no_deser", deser_cycles, 0);
    check("glitch_stp_kept", {31'd0, bus.stp_err}, {31'd0, exp_stp});
    check("glitch_par_kept", {31'd0, bus.par_err}, {31'd0, exp_par});

    // Reset in the middle of data bit 3.
    @(negedge CLK);
    RX_IN = 1'b0;
    sampled_m = 1'b0;
    repeat (36) @(negedge CLK);
    check("mid_bit_cnt", {28'd0, bus.bit_cnt}, 3);
    check("mid_deser_en", {31'd0, bus.deser_en}, 1);
    #1;
    RST = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge CLK);
    RX_IN = 1'b1;
    sampled_m = 1'b1;
    RST = 1'b1;
    @(negedge CLK);
    check("post_reset_idle", {31'd0, bus.dat_samp_en}, 0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);

    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge CLK);
    check("final_valid_low", {31'd0, bus.data_valid}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
